uart_pkt_tx: RTL and testbench
==============================

UART_PKT_TX -- requirements
Module: uart_pkt_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: byte-FIFO depth, a power of two.
REQ-002 Parameter STOP_BITS, default 1: stop bits per frame; legal values 1 and 2.
REQ-003 Parameters DIV_110, DIV_600, DIV_2400, DIV_9600, defaults 109091, 20000, 5000, 1250: clocks per bit at 12 MHz.
REQ-004 clk  input  1  single system clock, rising-edge.
REQ-005 nrst  input  1  asynchronous, active-low reset.
REQ-006 baud  input  2  rate select: 00=110, 01=600, 10=2400, 11=9600.
REQ-007 wr_en  input  1  push wr_data into the FIFO this cycle.
REQ-008 wr_data  input  8  byte to transmit.
REQ-009 tx  output  1  serial line, 8N1 (or 8N2), LSB first, idle high.
REQ-010 full  output  1  FIFO count == FIFO_DEPTH.
REQ-011 empty  output  1  FIFO count == 0.
REQ-012 count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-013 busy  output  1  FSM not in IDLE.
REQ-014 idle  output  1  FSM in IDLE and FIFO empty.
REQ-015 overflow  output  1  sticky flag; a write was dropped.

Function
REQ-016 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-017 The bit-period counter SHALL be 17 bits wide; each bit SHALL last exactly DIV cycles, where DIV is selected by baud.
REQ-018 baud SHALL be latched on the transition into START; a baud change mid-frame SHALL not affect the current frame.
REQ-019 IDLE -> START when the FIFO is not empty: the FIFO pops on that edge, the byte loads into the shift register, and tx = 0.
REQ-020 START -> DATA after DIV cycles; DATA shifts out bits 0..7 LSB first, each held for DIV cycles, on a 3-bit index.
REQ-021 DATA -> STOP after bit 7; tx = 1 for STOP_BITS*DIV cycles.
REQ-022 STOP exit: if the FIFO is not empty, go directly to START with a pop on the same edge (no idle gap between frames); otherwise go to IDLE.
REQ-023 Latency: wr_en sampled at edge N into an empty FIFO with the FSM in IDLE SHALL drive tx low after edge N+1.
REQ-024 tx SHALL be driven from a flop, with no combinational path from inputs.
REQ-025 full, empty and count SHALL reflect the registered count; push and pop in the same cycle SHALL leave count unchanged.
REQ-026 wr_en while full SHALL drop the byte, leave FIFO contents and pointers unchanged, and set overflow; this holds even if a pop occurs in the same cycle.
REQ-027 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 overflow SHALL be cleared only by reset.

Reset
REQ-029 nrst low SHALL immediately force: tx=1, state=IDLE, count=0, pointers=0, empty=1, full=0, busy=0, idle=1, overflow=0, shift register=0, bit counter=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame, raise tx the same instant, and discard all queued bytes; no partial frame resumes after release.
REQ-031 After release the first activity SHALL occur only on a new wr_en.

Verification
REQ-032 baud=11, push 0x5C -> tx low 1250 cycles, then bits 0,0,1,1,1,0,1,0 for 1250 cycles each, then high 1250 cycles; frame total 12500 cycles; idle=1 afterwards.
REQ-033 baud=11, push 0x53,0x01,0x02,0x02 on consecutive cycles -> four contiguous frames with no gap, 50000 cycles total, busy high throughout.
REQ-034 FIFO_DEPTH=8, ten consecutive pushes 0x00..0x09 into an idle block -> 0x00..0x08 transmitted in order, 0x09 dropped, overflow=1 and remains 1.
REQ-035 Frame 0xA5 in progress at baud=11, switch baud to 10 during bit 3 -> current frame keeps 1250-cycle bits; next queued frame 0xCC uses 5000-cycle bits.
REQ-036 nrst pulsed low during bit 4 of 0xA5 with 3 bytes queued -> tx=1 immediately, count=0; after release the line stays high with no further frames.
REQ-037 STOP_BITS=2, baud=11, push 0xFF,0x00 -> stop interval 2500 cycles between frames; total 2×13750 cycles.

Source files
------------

// File: rtl/uart_pkt_tx.sv
// Byte-FIFO-fed UART transmitter: 8 data bits, LSB first, 1 or 2 stop bits, four selectable baud rates.
// Queued bytes go out back-to-back. A write to a full FIFO is dropped and sets a sticky overflow flag.
module uart_pkt_tx #(
  parameter int FIFO_DEPTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int DIV_110    = 109091,
  parameter int DIV_600    = 20000,
  parameter int DIV_2400   = 5000,
  parameter int DIV_9600   = 1250
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic [1:0]                    baud,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          tx,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          busy,
  output logic                          idle,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e          state_q, state_d;
  logic [16:0]     div_q, div_d;
  logic [16:0]     cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            pop;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            overflow_q;
  logic            full_w, empty_w, push, bit_end;

  function automatic logic [16:0] div_sel(input logic [1:0] b);
    case (b)
      2'b00:   return 17'(DIV_110);
      2'b01:   return 17'(DIV_600);
      2'b10:   return 17'(DIV_2400);
      default: return 17'(DIV_9600);
    endcase
  endfunction

  assign full_w  = (count_q == CW'(FIFO_DEPTH));
  assign empty_w = (count_q == '0);
  // A write while full is dropped even if a pop frees a slot on the same edge.
  assign push    = wr_en && !full_w;
  assign bit_end = (cnt_q == div_q - 17'd1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  // NOTE: every signal gets a default first so no path through the case can infer a latch.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    cnt_d     = cnt_q + 17'd1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (!empty_w) begin
          state_d = S_START;
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          div_d   = div_sel(baud);
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          cnt_d     = '0;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d   = S_STOP;
            bit_idx_d = '0;
            tx_d      = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end
      end
      default: begin
        // Stop bits are counted one DIV at a time so the 17-bit counter never overflows.
        if (bit_end) begin
          cnt_d = '0;
          if (bit_idx_q == 3'(STOP_BITS - 1)) begin
            bit_idx_d = '0;
            if (!empty_w) begin
              state_d = S_START;
              pop     = 1'b1;
              shift_d = mem_q[rd_ptr_q];
              div_d   = div_sel(baud);
              tx_d    = 1'b0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
    endcase
  end

  always_comb begin
    tx       = tx_q;
    busy     = (state_q != S_IDLE);
    idle     = (state_q == S_IDLE) && empty_w;
    full     = full_w;
    empty    = empty_w;
    count    = count_q;
    overflow = overflow_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (wr_en && full_w) overflow_q <= 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_uart_pkt_tx.sv
// Scoreboard bench for uart_pkt_tx: expected frames are queued at push time and checked bit by bit
// by a line monitor. Short bit periods keep the run small.
module tb_uart_pkt_tx;

  localparam int D110  = 37;
  localparam int D600  = 23;
  localparam int D2400 = 20;
  localparam int D9600 = 10;

  logic       clk = 1'b0;
  logic       nrst;
  logic [1:0] baud;
  logic       wr_en, wr_en2;
  logic [7:0] wr_data, wr_data2;
  logic       tx1, full1, empty1, busy1, idle1, ovf1;
  logic       tx2, full2, empty2, busy2, idle2, ovf2;
  logic [3:0] count1, count2;

  uart_pkt_tx #(.FIFO_DEPTH(8), .STOP_BITS(1), .DIV_110(D110), .DIV_600(D600),
                .DIV_2400(D2400), .DIV_9600(D9600)) dut (
    .clk(clk), .nrst(nrst), .baud(baud), .wr_en(wr_en), .wr_data(wr_data),
    .tx(tx1), .full(full1), .empty(empty1), .count(count1), .busy(busy1),
    .idle(idle1), .overflow(ovf1));

  uart_pkt_tx #(.FIFO_DEPTH(8), .STOP_BITS(2), .DIV_110(D110), .DIV_600(D600),
                .DIV_2400(D2400), .DIV_9600(D9600)) dut2 (
    .clk(clk), .nrst(nrst), .baud(baud), .wr_en(wr_en2), .wr_data(wr_data2),
    .tx(tx2), .full(full2), .empty(empty2), .count(count2), .busy(busy2),
    .idle(idle2), .overflow(ovf2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         div;
  } exp_t;

  exp_t sb[$];
  int   starts[$];
  int   frames_seen = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic mon_sel = 1'b0;
  int   mon_stop = 1;

  wire mon_line = mon_sel ? tx2   : tx1;
  wire mon_idle = mon_sel ? idle2 : idle1;
  wire mon_busy = mon_sel ? busy2 : busy1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Line monitor: each falling edge on an idle line starts a frame, checked against the scoreboard head.
  initial begin : monitor
    exp_t e;
    int   nbits, match, k;
    bit   abort;
    logic exp_bit;
    forever begin
      @(negedge clk);
      if (nrst && mon_line === 1'b0) begin
        starts.push_back(cyc);
        frames_seen++;
        if (sb.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
          while (nrst && mon_line === 1'b0) @(negedge clk);
        end else begin
          e     = sb.pop_front();
          nbits = 9 + mon_stop;
          match = 0;
          abort = 1'b0;
          for (int i = 0; i < nbits * e.div && !abort; i++) begin
            if (i > 0) @(negedge clk);
            if (!nrst) abort = 1'b1;
            else begin
              k       = i / e.div;
              exp_bit = (k == 0) ? 1'b0 : (k <= 8) ? e.data[k-1] : 1'b1;
              if (mon_line === exp_bit) match++;
              if (i % e.div == e.div - 1) begin
                check($sformatf("frame%02h_bit%0d_cycles", e.data, k), match, e.div);
                match = 0;
              end
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [7:0] b, input bit exp, input int div);
    exp_t e;
    if (mon_sel) begin wr_en2 = 1'b1; wr_data2 = b; end
    else         begin wr_en  = 1'b1; wr_data  = b; end
    if (exp) begin
      e.data = b;
      e.div  = div;
      sb.push_back(e);
    end
    @(negedge clk);
    wr_en  = 1'b0;
    wr_en2 = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int t, output int busy_lo);
    t = -1;
    busy_lo = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mon_idle) begin
        t = cyc;
        break;
      end
      if (!mon_busy) busy_lo++;
    end
    if (t < 0) begin
      check("idle_timeout", 32'd0, 32'd1);
      t = cyc;
    end
  endtask

  task automatic wait_frames(input int n, input int budget);
    int i;
    i = 0;
    while (frames_seen < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("frame_start_timeout", 32'(frames_seen >= n), 32'd1);
  endtask

  task automatic new_test();
    starts.delete();
    frames_seen = 0;
  endtask

  int t, bl, n, lo;

  initial begin : stim
    nrst = 1'b0; baud = 2'b11;
    wr_en = 1'b0; wr_en2 = 1'b0; wr_data = '0; wr_data2 = '0;
    repeat (3) @(negedge clk);
    check("rst_tx",    tx1,    1'b1);
    check("rst_count", count1, 4'd0);
    check("rst_empty", empty1, 1'b1);
    check("rst_full",  full1,  1'b0);
    check("rst_busy",  busy1,  1'b0);
    check("rst_idle",  idle1,  1'b1);
    check("rst_ovf",   ovf1,   1'b0);
    check("rst_tx2",   tx2,    1'b1);
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_quiet", tx1, 1'b1);

    // Single frame 0x5C: start latency and frame length.
    new_test();
    push(8'h5C, 1'b1, D9600);
    check("lat_tx_still_high", tx1, 1'b1);
    check("count_after_push",  count1, 4'd1);
    @(negedge clk);
    check("lat_tx_low",        tx1, 1'b0);
    check("count_after_pop",   count1, 4'd0);
    check("busy_in_frame",     busy1, 1'b1);
    wait_idle(500, t, bl);
    check("frame_5c_len", t - starts[0], 10 * D9600);
    check("idle_after_5c", idle1, 1'b1);

    // Four back-to-back frames.
    new_test();
    push(8'h53, 1'b1, D9600);
    push(8'h01, 1'b1, D9600);
    push(8'h02, 1'b1, D9600);
    push(8'h02, 1'b1, D9600);
    wait_idle(1000, t, bl);
    check("b2b_frames", frames_seen, 4);
    check("b2b_total", t - starts[0], 40 * D9600);
    check("b2b_busy_gaps", bl, 0);
    for (int i = 1; i < starts.size(); i++)
      check($sformatf("b2b_gap%0d", i), starts[i] - starts[i-1], 10 * D9600);

    // Overflow: ten pushes, ninth accepted byte fills the FIFO, 0x09 dropped.
    new_test();
    for (int b = 0; b < 10; b++) push(8'(b), b < 9, D9600);
    check("ovf_full",  full1,  1'b1);
    check("ovf_count", count1, 4'd8);
    check("ovf_flag",  ovf1,   1'b1);
    // Keep writing while full, across the pop edge: every one of these must be dropped.
    wr_en = 1'b1; wr_data = 8'hEE;
    n = 0;
    while (full1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    wr_en = 1'b0;
    check("ovf_full_released", full1, 1'b0);
    check("ovf_count_after_pop", count1, 4'd7);
    wait_idle(3000, t, bl);
    check("ovf_frames", frames_seen, 9);
    check("ovf_sticky", ovf1, 1'b1);
    check("ovf_sb_drained", sb.size(), 0);

    // Baud change mid-frame applies only to the next frame.
    new_test();
    push(8'hA5, 1'b1, D9600);
    push(8'hCC, 1'b1, D2400);
    wait_frames(1, 100);
    while (cyc < starts[0] + 4 * D9600 + 3) @(negedge clk);
    baud = 2'b10;
    wait_idle(1000, t, bl);
    check("baud_frames", frames_seen, 2);
    if (starts.size() == 2) begin
      check("baud_gap", starts[1] - starts[0], 10 * D9600);
      check("baud_cc_len", t - starts[1], 10 * D2400);
    end

    // The two slow rates.
    baud = 2'b00;
    new_test();
    push(8'h3C, 1'b1, D110);
    wait_idle(1000, t, bl);
    check("baud110_len", t - starts[0], 10 * D110);
    baud = 2'b01;
    new_test();
    push(8'h81, 1'b1, D600);
    wait_idle(1000, t, bl);
    check("baud600_len", t - starts[0], 10 * D600);

    // Reset during bit 4 of 0xA5 with three bytes queued.
    baud = 2'b11;
    new_test();
    push(8'hA5, 1'b1, D9600);
    push(8'h11, 1'b0, D9600);
    push(8'h22, 1'b0, D9600);
    push(8'h33, 1'b0, D9600);
    wait_frames(1, 100);
    while (cyc < starts[0] + 5 * D9600 + D9600 / 2) @(negedge clk);
    check("pre_rst_count", count1, 4'd3);
    #2 nrst = 1'b0;
    #1;
    check("midrst_tx",    tx1,    1'b1);
    check("midrst_count", count1, 4'd0);
    check("midrst_empty", empty1, 1'b1);
    check("midrst_busy",  busy1,  1'b0);
    check("midrst_idle",  idle1,  1'b1);
    check("midrst_ovf",   ovf1,   1'b0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    sb.delete();
    lo = 0;
    repeat (400) begin
      @(negedge clk);
      if (tx1 !== 1'b1) lo++;
    end
    check("post_rst_line_low_cycles", lo, 0);
    check("post_rst_frames", frames_seen, 1);
    check("post_rst_idle", idle1, 1'b1);

    // Two stop bits on the second instance.
    mon_sel = 1'b1;
    mon_stop = 2;
    new_test();
    push(8'hFF, 1'b1, D9600);
    push(8'h00, 1'b1, D9600);
    wait_idle(1000, t, bl);
    check("stop2_frames", frames_seen, 2);
    if (starts.size() == 2) begin
      check("stop2_gap", starts[1] - starts[0], 11 * D9600);
      check("stop2_total", t - starts[0], 22 * D9600);
    end
    check("final_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
